// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, clocks a command byte out
// on device-generated clock edges and checks the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_END  = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_STOP    = 3'd4;
  localparam logic [2:0] ST_ACK     = 3'd5;
  localparam logic [2:0] ST_RELEASE = 3'd6;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  logic          clk_meta_r, clk_sync_r, clk_prev_r;
  logic          data_meta_r, data_sync_r;
  logic [2:0]    state_r, state_s;
  logic [IW-1:0] inh_cnt_r, inh_cnt_s;
  logic [TW-1:0] to_cnt_r, to_cnt_s;
  logic [3:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    byte_r, byte_s;
  logic          parity_r, parity_s;
  logic          clk_oe_r, clk_oe_s, data_oe_r, data_oe_s;
  logic          done_r, done_s, error_r, error_s;
  logic          tx_ready_r, busy_r;
  logic          fall_s, timed_s, expire_s;

  assign fall_s   = clk_prev_r & ~clk_sync_r;
  assign timed_s  = (state_r == ST_START) || (state_r == ST_SEND) || (state_r == ST_STOP) ||
                    (state_r == ST_ACK) || (state_r == ST_RELEASE);
  assign expire_s = (to_cnt_r == TO_LAST) & ~fall_s;

  // Two-flop synchronizers for both bus lines plus the falling-edge history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_in;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  // Next-state, counter and next-output logic; outputs are registered below.
  always_comb begin
    state_s   = state_r;
    inh_cnt_s = inh_cnt_r;
    to_cnt_s  = '0;
    bit_idx_s = bit_idx_r;
    byte_s    = byte_r;
    parity_s  = parity_r;
    clk_oe_s  = clk_oe_r;
    data_oe_s = data_oe_r;
    done_s    = 1'b0;
    error_s   = 1'b0;
    if (timed_s) begin
      to_cnt_s = fall_s ? '0 : (to_cnt_r + TW'(1));
    end else begin
      to_cnt_s = '0;
    end
    case (state_r)
      ST_IDLE: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        inh_cnt_s = '0;
        bit_idx_s = 4'd0;
        if (tx_valid) begin
          byte_s   = tx_data;
          parity_s = odd_parity(tx_data);
          clk_oe_s = 1'b1;
          state_s  = ST_INHIBIT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_r == INH_END) begin
          clk_oe_s  = 1'b0;
          data_oe_s = 1'b1;
          state_s   = ST_START;
        end else if (inh_cnt_r == INH_LAST) begin
          data_oe_s = 1'b1;
          inh_cnt_s = inh_cnt_r + IW'(1);
        end else begin
          inh_cnt_s = inh_cnt_r + IW'(1);
        end
      end
      ST_START: begin
        state_s = ST_SEND;
      end
      ST_SEND: begin
        // Edge n (1-based) presents bit n-1; edge 9 presents parity, edge 10 the stop bit.
        if (fall_s) begin
          bit_idx_s = bit_idx_r + 4'd1;
          if (bit_idx_r < 4'd8) begin
            data_oe_s = ~byte_r[bit_idx_r[2:0]];
          end else if (bit_idx_r == 4'd8) begin
            data_oe_s = ~parity_r;
          end else begin
            data_oe_s = 1'b0;
            state_s   = ST_STOP;
          end
        end else begin
          bit_idx_s = bit_idx_r;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_s = ST_ACK;
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_ACK: begin
        if (!data_sync_r) begin
          state_s = ST_RELEASE;
        end else begin
          state_s = ST_IDLE;
          error_s = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (clk_sync_r && data_sync_r) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_RELEASE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
      end
    endcase
    if (timed_s && expire_s) begin
      state_s   = ST_IDLE;
      to_cnt_s  = '0;
      clk_oe_s  = 1'b0;
      data_oe_s = 1'b0;
      done_s    = 1'b0;
      error_s   = 1'b1;
    end else begin
      error_s   = error_s;
    end
    if (state_s == ST_IDLE) begin
      clk_oe_s  = 1'b0;
      data_oe_s = 1'b0;
      bit_idx_s = 4'd0;
    end else begin
      bit_idx_s = bit_idx_s;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      inh_cnt_r  <= '0;
      to_cnt_r   <= '0;
      bit_idx_r  <= 4'd0;
      byte_r     <= 8'd0;
      parity_r   <= 1'b0;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      inh_cnt_r  <= inh_cnt_s;
      to_cnt_r   <= to_cnt_s;
      bit_idx_r  <= bit_idx_s;
      byte_r     <= byte_s;
      parity_r   <= parity_s;
      clk_oe_r   <= clk_oe_s;
      data_oe_r  <= data_oe_s;
      done_r     <= done_s;
      error_r    <= error_s;
      tx_ready_r <= (state_s == ST_IDLE);
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign done        = done_r;
  assign error       = error_r;
  assign tx_ready    = tx_ready_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host and the recorded line bits are compared with hand-computed frames.
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int TO  = 5000;
  localparam int HP  = 20;
  localparam int LP  = 20;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       par;
    logic       exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, busy, done, error;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int viol = 0;
  logic       err_ready = 1'b0;
  logic [1:0] err_oe = 2'b00;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (error === 1'b1) begin
      err_cnt   = err_cnt + 1;
      err_cyc   = cyc;
      err_ready = tx_ready;
      err_oe    = {ps2_clk_oe, ps2_data_oe};
    end
    if ((done === 1'b1 && error === 1'b1) || (busy === tx_ready)) viol = viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Device side: watch the inhibit, then generate 11 clock pulses, recording the line before each fall.
  task automatic dev_transfer(input logic ack, input int rst_at, output logic [10:0] frame,
                              output int inh, output int both);
    int n;
    n = 0; inh = 0; both = 0; frame = '1;
    while (ps2_clk_oe !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    while (ps2_clk_oe === 1'b1 && n < 2000) begin
      if (ps2_data_oe === 1'b1) both++; else inh++;
      @(negedge clk); n++;
    end
    if (n >= 2000) begin
      bound_fail("inhibit_wait");
      return;
    end
    for (int k = 0; k < 11; k++) begin
      repeat (HP - 1) @(negedge clk);
      frame[k] = ps2_data_in;
      if (k == 10) dev_data = ~ack;
      @(negedge clk);
      dev_clk = 1'b0;
      if (k + 1 == rst_at) begin
        repeat (LP / 2) @(negedge clk);
        check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_async_data_oe", 32'(ps2_data_oe), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        return;
      end
      repeat (LP) @(negedge clk);
      dev_clk = 1'b1;
      dev_data = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [10:0] fr;
    int inh, both, d0, e0, n;
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    check("ready_before", 32'(tx_ready), 32'd1);
    tx_data = v.data; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = ~v.data;
    dev_transfer(v.ack, 0, fr, inh, both);
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check("inhibit_len", 32'(inh), 32'(INH));
    check("inhibit_data_cycle", 32'(both), 32'd1);
    check("start_bit", 32'(fr[0]), 32'd0);
    check("data_bits", 32'(fr[8:1]), 32'(v.data));
    check("parity_bit", 32'(fr[9]), 32'(v.par));
    check("stop_bit", 32'(fr[10]), 32'd1);
    check("done_count", 32'(done_cnt - d0), 32'(v.exp_done));
    check("error_count", 32'(err_cnt - e0), 32'(!v.exp_done));
    check("end_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("ready_after", 32'(tx_ready), 32'd1);
    if (!v.exp_done) check("ready_at_error", 32'(err_ready), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    logic [10:0] fr;
    int inh, both, d0, e0, n, c0;
    vecs[0] = '{data: 8'hED, ack: 1'b1, par: 1'b1, exp_done: 1'b1};
    vecs[1] = '{data: 8'h00, ack: 1'b1, par: 1'b1, exp_done: 1'b1};
    vecs[2] = '{data: 8'h01, ack: 1'b1, par: 1'b0, exp_done: 1'b1};
    vecs[3] = '{data: 8'hF4, ack: 1'b1, par: 1'b0, exp_done: 1'b1};
    vecs[4] = '{data: 8'hFF, ack: 1'b0, par: 1'b1, exp_done: 1'b0};
    vecs[5] = '{data: 8'h55, ack: 1'b1, par: 1'b1, exp_done: 1'b1};

    repeat (3) @(negedge clk);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(tx_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Device never clocks: abort exactly TO cycles after START entry.
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    tx_data = 8'h12; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) bound_fail("start_wait");
    c0 = cyc;
    n = 0;
    while (err_cnt == e0 && n < TO + 1000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("timeout_err_count", 32'(err_cnt - e0), 32'd1);
    check("timeout_latency", 32'(err_cyc - c0), 32'(TO));
    check("timeout_oe", 32'(err_oe), 32'd0);
    check("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    check("timeout_ready", 32'(tx_ready), 32'd1);

    // Reset asserted in the middle of SEND.
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    tx_data = 8'hF4; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_transfer(1'b1, 4, fr, inh, both);
    repeat (2) @(negedge clk);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_no_error", 32'(err_cnt - e0), 32'd0);
    run_vec(vecs[3]);

    // tx_valid held high with tx_data changing mid-transfer.
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clk);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h3C;
    dev_transfer(1'b1, 0, fr, inh, both);
    check("held_first_byte", 32'(fr[8:1]), 32'hA5);
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) bound_fail("held_done_wait");
    @(negedge clk);
    check("held_reaccept", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    dev_transfer(1'b1, 0, fr, inh, both);
    check("held_second_byte", 32'(fr[8:1]), 32'h3C);
    n = 0;
    while (done_cnt - d0 < 2 && n < 100) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check("held_done_count", 32'(done_cnt - d0), 32'd2);
    check("held_error_count", 32'(err_cnt - e0), 32'd0);

    check("busy_ready_exclusive", 32'(viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
